// File: rtl/pwm_pkg.sv
// Shared defaults for the PWM generator and its optional dead-time stage.
package pwm_pkg;
  localparam int DEFAULT_DUTY_NOB = 11;
  localparam int DEFAULT_PERIOD   = 100;
  localparam int DEFAULT_DEADTIME = 2;
endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: turns the raw PWM drive into a non-overlapping pwm/pwm_n pair.
// An output only rises once raw has held its level for DEADTIME+1 consecutive clocks.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEADTIME = DEFAULT_DEADTIME
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic raw,
  output logic pwm,
  output logic pwm_n
);

  localparam int RUN_W = $clog2(DEADTIME + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEADTIME + 1);

  logic             raw_prev_q, raw_prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_now;
  logic             pwm_q, pwm_d;
  logic             pwm_n_q, pwm_n_d;

  // run_now is the length of the current raw level, including this cycle, saturating.
  always_comb begin
    run_now = RUN_W'(1);
    if (raw == raw_prev_q) begin
      run_now = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
    end
    raw_prev_d = enable && raw;
    run_d      = enable ? run_now : '0;
    pwm_d      = enable && raw && (run_now == RUN_MAX);
    pwm_n_d    = enable && !raw && (run_now == RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_prev_q <= 1'b0;
      run_q      <= '0;
      pwm_q      <= 1'b0;
      pwm_n_q    <= 1'b0;
    end else begin
      raw_prev_q <= raw_prev_d;
      run_q      <= run_d;
      pwm_q      <= pwm_d;
      pwm_n_q    <= pwm_n_d;
    end
  end

  assign pwm   = pwm_q;
  assign pwm_n = pwm_n_q;

endmodule

// File: rtl/pwm_generator.sv
// Period-counter PWM with a shadowed duty register and period_start/duty_clamped flags.
// Define PWM_COMPLEMENTARY_EN to add the pwm_n output with dead-time insertion.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int DUTY_NOB = DEFAULT_DUTY_NOB,
  parameter int PERIOD   = DEFAULT_PERIOD,
  parameter int DEADTIME = DEFAULT_DEADTIME
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [DUTY_NOB-1:0] duty,
  output logic                pwm,
  output logic                pwm_n,
  output logic                period_start,
  output logic                duty_clamped
);

  if (PERIOD < 2 || PERIOD > (2 ** DUTY_NOB) - 1) begin : g_bad_period
    $error("pwm_generator: PERIOD out of range");
  end
  if (DEADTIME < 1 || DEADTIME > PERIOD / 4) begin : g_bad_deadtime
    $error("pwm_generator: DEADTIME out of range");
  end

  localparam logic [DUTY_NOB-1:0] PERIOD_V = DUTY_NOB'(PERIOD);
  localparam logic [DUTY_NOB-1:0] LAST_V   = DUTY_NOB'(PERIOD - 1);

  logic [DUTY_NOB-1:0] cnt_q, cnt_d;
  logic [DUTY_NOB-1:0] duty_q, duty_d;
  logic                clamped_q, clamped_d;
  logic                start_q, start_d;
  logic                raw;

  // Duty is only re-latched while idle or on the last count, so a period never changes mid-flight.
  always_comb begin
    cnt_d     = '0;
    duty_d    = duty_q;
    clamped_d = clamped_q;
    if (enable && cnt_q != LAST_V) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (!enable || cnt_q == LAST_V) begin
      duty_d    = (duty > PERIOD_V) ? PERIOD_V : duty;
      clamped_d = duty > PERIOD_V;
    end
    raw     = enable && (cnt_q < duty_q);
    start_d = enable && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      duty_q    <= '0;
      clamped_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      clamped_q <= clamped_d;
      start_q   <= start_d;
    end
  end

  assign period_start = start_q;
  assign duty_clamped = clamped_q;

`ifdef PWM_COMPLEMENTARY_EN
  pwm_deadtime #(
    .DEADTIME(DEADTIME)
  ) u_deadtime (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .raw   (raw),
    .pwm   (pwm),
    .pwm_n (pwm_n)
  );
`else
  logic pwm_q, pwm_d;

  always_comb begin
    pwm_d = raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm   = pwm_q;
  assign pwm_n = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator (PERIOD=100, DEADTIME=2) against a period/duty reference model.
module tb_pwm_generator;

  localparam int PERIOD = 100;
  localparam int DT     = 2;
  localparam int NOB    = 11;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [NOB-1:0] duty;
  logic           pwm, pwm_n, period_start, duty_clamped;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_generator #(
    .DUTY_NOB(NOB),
    .PERIOD  (PERIOD),
    .DEADTIME(DT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .duty        (duty),
    .pwm         (pwm),
    .pwm_n       (pwm_n),
    .period_start(period_start),
    .duty_clamped(duty_clamped)
  );

  // Reference: within a period, output position p is high iff p < min(duty, PERIOD).
  function automatic int lat(input int d);
    return (d > PERIOD) ? PERIOD : d;
  endfunction

  // Latch duty while idle, then enable so the next posedge is the first cnt==0 cycle.
  task automatic start_run(input int d);
    @(negedge clk);
    duty   = NOB'(d);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset  = 1'b1;
    enable = 1'b1;
    duty   = NOB'(55);
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {pwm, pwm_n, period_start, duty_clamped};
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want 0000", got);
    end
    reset  = 1'b0;
    enable = 1'b0;
    duty   = NOB'(2047);
    @(negedge clk);
    total++;
    if (duty_clamped !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_clamp_load: got %b want 1", duty_clamped);
    end
    reset = 1'b1;
    @(negedge clk);
    got = {pwm, pwm_n, period_start, duty_clamped};
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_clears_clamp: got %b want 0000", got);
    end
    reset = 1'b0;
  endtask

  task automatic test_steady(input int d, input int nper);
    logic [3:0] got, exp;
    int pos;
    start_run(d);
    for (int k = 0; k < nper * PERIOD; k++) begin
      @(negedge clk);
      pos = k % PERIOD;
      got = {pwm, period_start, duty_clamped, pwm_n};
      exp = {pos < lat(d), pos == 0, d > PERIOD, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL steady d=%0d k=%0d: got %b want %b", d, k, got, exp);
      end
    end
    stop_run();
  endtask

  task automatic test_duty_change();
    logic [3:0] got, exp;
    int pos, dl;
    start_run(55);
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge clk);
      pos = k % PERIOD;
      dl  = (k < PERIOD) ? 55 : 60;
      got = {pwm, period_start, duty_clamped, pwm_n};
      exp = {pos < dl, pos == 0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL duty_change k=%0d: got %b want %b", k, got, exp);
      end
      if (k == 19) duty = NOB'(60);
    end
    stop_run();
  endtask

  task automatic test_disable();
    logic [3:0] got, exp;
    int pos;
    start_run(55);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      got = {pwm, period_start, duty_clamped, pwm_n};
      exp = {k < 55, k == 0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL pre_disable k=%0d: got %b want %b", k, got, exp);
      end
    end
    enable = 1'b0;
    duty   = NOB'(70);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = {pwm, period_start, duty_clamped, pwm_n};
      total++;
      if (got !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL disabled_idle i=%0d: got %b want 0000", i, got);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge clk);
      pos = k % PERIOD;
      got = {pwm, period_start, duty_clamped, pwm_n};
      exp = {pos < 70, pos == 0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL reenable k=%0d: got %b want %b", k, got, exp);
      end
    end
    stop_run();
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, exp;
    int pos, dl;
    start_run(55);
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      got = {pwm, period_start, duty_clamped, pwm_n};
      exp = {k < 55, k == 0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL pre_reset k=%0d: got %b want %b", k, got, exp);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = {pwm, period_start, duty_clamped, pwm_n};
      total++;
      if (got !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL mid_reset i=%0d: got %b want 0000", i, got);
      end
    end
    reset = 1'b0;
    // Reset zeroed the shadow duty, so the first period after release is all-low.
    for (int k = 0; k < 3 * PERIOD; k++) begin
      @(negedge clk);
      pos = k % PERIOD;
      dl  = (k < PERIOD) ? 0 : 55;
      got = {pwm, period_start, duty_clamped, pwm_n};
      exp = {pos < dl, pos == 0, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL post_reset k=%0d: got %b want %b", k, got, exp);
      end
    end
    stop_run();
  endtask

`ifdef PWM_COMPLEMENTARY_EN
  task automatic test_deadtime(input int d);
    logic [2:0] got, exp;
    int pos;
    start_run(d);
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge clk);
      pos = k % PERIOD;
      got = {pwm, pwm_n, period_start};
      exp = {pos >= DT && pos < d, pos >= d + DT, pos == 0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("[TB] FAIL deadtime d=%0d k=%0d: got %b want %b", d, k, got, exp);
      end
    end
    stop_run();
  endtask
`endif

  initial begin
    int fixed_duties[7] = '{55, 0, 100, 2047, 1, 99, 101};
    reset  = 1'b0;
    enable = 1'b0;
    duty   = '0;
    test_reset();
`ifdef PWM_COMPLEMENTARY_EN
    test_deadtime(50);
    test_deadtime(1);
    test_deadtime(30);
`else
    foreach (fixed_duties[i]) test_steady(fixed_duties[i], 2);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) test_steady(int'($urandom_range(0, 110)), 2);
      else test_steady(int'($urandom_range(0, 2047)), 2);
    end
    test_duty_change();
    test_disable();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter DUTY_NOB, default 11: width of the duty input, matching the triangular counter output width.
REQ-002 Parameter PERIOD, default 100: PWM period in clk cycles, range 2..2**DUTY_NOB-1.
REQ-003 Parameter DEADTIME, default 2: dead-time in clk cycles, range 1..PERIOD/4; used only when PWM_COMPLEMENTARY_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high runs the PWM; low idles it.
REQ-007 duty  input  DUTY_NOB  requested high-time in clk cycles, driven by the upstream triangular counter.
REQ-008 pwm  output  1  registered PWM output.
REQ-009 pwm_n  output  1  registered complementary output; constant 0 when the feature is compiled out.
REQ-010 period_start  output  1  registered one-clock pulse at the first cycle of every PWM period.
REQ-011 duty_clamped  output  1  registered; high while the latched duty was clamped to PERIOD.

Function
REQ-012 Internal period counter cnt SHALL count 0..PERIOD-1 while enable=1, wrapping to 0 after PERIOD-1.
REQ-013 While enable=0, cnt SHALL be held at 0, and pwm, pwm_n and period_start SHALL be 0.
REQ-014 Shadow register duty_q SHALL load min(duty, PERIOD) when enable=0 or cnt==PERIOD-1; duty changes at other times SHALL have no effect until the next period.
REQ-015 duty_clamped SHALL load (duty > PERIOD) on the same cycles that duty_q loads.
REQ-016 The raw drive SHALL equal enable && (cnt < duty_q); pwm SHALL follow it with exactly 1 clk latency (feature compiled out).
REQ-017 Per PERIOD-clock period, pwm SHALL be high for exactly duty_q clocks, contiguously, starting at the period's first output cycle.
REQ-018 duty_q=0 SHALL keep pwm at 0 for the whole period; duty_q=PERIOD SHALL keep pwm at 1 with no glitch across the wrap.
REQ-019 period_start SHALL pulse for one clock, aligned with the pwm output cycle that corresponds to cnt==0, each period while enable=1.
REQ-020 On an enable rising edge, the first period SHALL start with cnt=0, using the duty_q captured on the previous cycle.
REQ-021 Deassertion of enable mid-period SHALL force pwm=0 on the next clock and abort the period.

Reset
REQ-022 reset=1 SHALL set cnt=0, duty_q=0, pwm=0, pwm_n=0, period_start=0 and duty_clamped=0 on the next posedge, overriding enable.
REQ-023 Reset asserted mid-period SHALL abort the period; after release, operation SHALL follow REQ-020.

Configuration
REQ-024 Macro PWM_COMPLEMENTARY_EN, when defined, SHALL enable dead-time insertion:
- raw rise: pwm_n falls on the next clock; pwm rises DEADTIME clocks later.
- raw fall: pwm falls on the next clock; pwm_n rises DEADTIME clocks later.
REQ-025 With the macro defined, pwm and pwm_n SHALL never both be 1.
- A raw high or low pulse of DEADTIME clocks or fewer SHALL suppress the corresponding output rise entirely.
REQ-026 Without the macro, pwm_n SHALL be tied to 0, no dead-time logic SHALL be synthesized, and pwm SHALL follow REQ-016.

Structure
REQ-027 Shared package pwm_pkg SHALL hold the default PERIOD, DEADTIME and DUTY_NOB constants.
REQ-028 Dead-time logic SHALL be a separate sub-module, pwm_deadtime, instantiated only under PWM_COMPLEMENTARY_EN.

Verification (PERIOD=100, DEADTIME=2)
REQ-029 enable=1, duty=55 -> pwm high 55 / low 45 clocks per period; period_start pulses every 100 clocks.
REQ-030 Change duty 55->60 at cnt=20 -> current period high 55 clocks; next period high 60 clocks.
REQ-031 duty=0 -> pwm constantly 0. duty=100 -> pwm constantly 1, duty_clamped=0. duty=2047 -> pwm constantly 1, duty_clamped=1.
REQ-032 Drop enable at cnt=30 -> pwm=0 next clock. Re-enable -> full new period, period_start on its first output cycle.
REQ-033 Macro defined, duty=50 -> pwm high 48 clocks, pwm_n high 48 clocks, two 2-clock both-low gaps, never both high. duty=1 -> pwm never high.
REQ-034 Assert reset at cnt=70 with duty=55 -> all outputs 0 on the next clock. Release -> REQ-029 behaviour resumes.
